// File: rtl/smart_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smart_uart_pkg
//  Description : Shared types and constants for the smart-uart TX path.
//                Holds the arbiter state encoding, one-hot grant codes, the
//                response packet length and the response command byte.
//  Revision    : 1.0  initial release
// ============================================================================
package smart_uart_pkg;

    // Arbiter owner state
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CON = 2'd1,
        GNT_RSP = 2'd2
    } su_arb_state_t;

    // One-hot grant codes presented on the grant output
    localparam logic [1:0] SU_GNT_CON = 2'b01;
    localparam logic [1:0] SU_GNT_RSP = 2'b10;

    // A smart-uart response is SU_CMD_RSP followed by 4 data bytes
    localparam int         SU_RSP_LEN = 5;
    localparam logic [7:0] SU_CMD_RSP = 8'hA5;

    // Grant code that belongs to a given owner state
    function automatic logic [1:0] su_grant_of(input su_arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            GNT_CON: g = SU_GNT_CON;
            GNT_RSP: g = SU_GNT_RSP;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/su_tx_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : su_tx_out_reg
//  Description : Single-entry registered valid/ready stage in front of
//                uart_tx. Accepts a new byte whenever it is empty or its
//                current byte leaves in the same cycle, giving 1 byte/cycle.
//  Ports       : clk, rstn          clock, synchronous active-low reset
//                in_valid/in_data   upstream beat, in_ready accept
//                out_valid/out_data registered beat, out_ready from sink
//  Revision    : 1.0  initial release
// ============================================================================
module su_tx_out_reg (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready
);

    logic       r_valid;
    logic [7:0] r_data;

    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (in_valid && in_ready) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/su_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : su_tx_arbiter
//  Description : Packet-granular arbiter sharing the UART TX byte stream
//                between console text and smart-uart responses. A whole
//                packet is granted at a time so a response is never split
//                by console bytes. Responses win ties, but after
//                MAX_RSP_BURST consecutive responses a waiting console
//                packet is served. A stall timeout releases a hung owner.
//  Ports       : clk, rstn                     clock, sync active-low reset
//                con_valid/con_data/con_last   console source, con_ready
//                rsp_valid/rsp_data/rsp_last   response source, rsp_ready
//                tx_valid/tx_data, tx_ready    registered stream to uart_tx
//                grant                         one-hot owner (00 idle)
//                timeout_err                   1-cycle forced-release pulse
//  Revision    : 1.0  initial release
// ============================================================================
module su_tx_arbiter
    import smart_uart_pkg::*;
#(
    parameter int MAX_RSP_BURST  = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       con_valid,
    input  logic [7:0] con_data,
    input  logic       con_last,
    output logic       con_ready,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    input  logic       rsp_last,
    output logic       rsp_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int BURST_W = $clog2(MAX_RSP_BURST + 1);
    localparam logic [BURST_W-1:0]  c_burst_max = BURST_W'(MAX_RSP_BURST);
    localparam bit                  c_to_en     = (TIMEOUT_CYCLES != 0);
    // Release fires on the idle cycle that would bring the count to TIMEOUT_CYCLES
    localparam logic [TO_CNT_W-1:0] c_to_last   = TO_CNT_W'(TIMEOUT_CYCLES - 1);

    su_arb_state_t       r_state;
    su_arb_state_t       w_state_nxt;
    logic [BURST_W-1:0]  r_burst_cnt;
    logic [BURST_W-1:0]  w_burst_nxt;
    logic [TO_CNT_W-1:0] r_to_cnt;
    logic [TO_CNT_W-1:0] w_to_nxt;
    logic [1:0]          r_grant;
    logic                r_timeout_err;
    logic                w_to_fire;

    logic                w_slot_free;
    logic                w_beat_valid;
    logic [7:0]          w_beat_data;
    logic                w_beat_last;
    logic                w_acc;

    // Granted source seen by the output stage; nothing passes while IDLE
    always_comb begin
        w_beat_valid = 1'b0;
        w_beat_data  = 8'h00;
        w_beat_last  = 1'b0;
        case (r_state)
            GNT_CON: begin
                w_beat_valid = con_valid;
                w_beat_data  = con_data;
                w_beat_last  = con_last;
            end
            GNT_RSP: begin
                w_beat_valid = rsp_valid;
                w_beat_data  = rsp_data;
                w_beat_last  = rsp_last;
            end
            default: ;
        endcase
    end

    assign con_ready = (r_state == GNT_CON) && w_slot_free;
    assign rsp_ready = (r_state == GNT_RSP) && w_slot_free;
    assign w_acc     = w_beat_valid && w_slot_free;

    su_tx_out_reg u_out_reg (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (w_beat_valid),
        .in_data   (w_beat_data),
        .in_ready  (w_slot_free),
        .out_valid (tx_valid),
        .out_data  (tx_data),
        .out_ready (tx_ready)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_to_nxt    = r_to_cnt;
        w_to_fire   = 1'b0;
        case (r_state)
            IDLE: begin
                w_to_nxt = '0;
                if (rsp_valid && (!con_valid || (r_burst_cnt != c_burst_max))) begin
                    w_state_nxt = GNT_RSP;
                end else if (con_valid) begin
                    w_state_nxt = GNT_CON;
                end
                // A response grant with no console waiting ends the burst run
                if (rsp_valid && !con_valid) begin
                    w_burst_nxt = '0;
                end
            end
            GNT_CON, GNT_RSP: begin
                if (w_acc) begin
                    // An accept needs valid high, so it can never coincide
                    // with an idle count: the accept always wins.
                    w_to_nxt = '0;
                    if (w_beat_last) begin
                        w_state_nxt = IDLE;
                        if (r_state == GNT_CON) begin
                            w_burst_nxt = '0;
                        end else if (r_burst_cnt != c_burst_max) begin
                            w_burst_nxt = r_burst_cnt + 1'b1;
                        end
                    end
                end else if (c_to_en && !w_beat_valid && tx_ready) begin
                    if (r_to_cnt == c_to_last) begin
                        w_state_nxt = IDLE;
                        w_to_fire   = 1'b1;
                        w_to_nxt    = '0;
                    end else begin
                        w_to_nxt = r_to_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_to_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= IDLE;
            r_burst_cnt   <= '0;
            r_to_cnt      <= '0;
            r_grant       <= 2'b00;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_burst_cnt   <= w_burst_nxt;
            r_to_cnt      <= w_to_nxt;
            r_grant       <= su_grant_of(w_state_nxt);
            r_timeout_err <= w_to_fire;
        end
    end

    assign grant       = r_grant;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_su_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_su_tx_arbiter
//  Description : Directed self-checking bench for su_tx_arbiter
//                (MAX_RSP_BURST=4, TIMEOUT_CYCLES=20).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_su_tx_arbiter;
    import smart_uart_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       con_valid = 1'b0;
    logic [7:0] con_data = 8'h00;
    logic       con_last = 1'b0;
    logic       con_ready;
    logic       rsp_valid = 1'b0;
    logic [7:0] rsp_data = 8'h00;
    logic       rsp_last = 1'b0;
    logic       rsp_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;
    logic [1:0] grant;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int to_pulses = 0;

    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];
    logic [8:0] con_q[$];
    logic [8:0] rsp_q[$];
    logic [7:0] held;
    int         pulses_base;

    su_tx_arbiter #(
        .MAX_RSP_BURST  (4),
        .TIMEOUT_CYCLES (20),
        .TO_CNT_W       (5)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .con_valid   (con_valid),
        .con_data    (con_data),
        .con_last    (con_last),
        .con_ready   (con_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .rsp_ready   (rsp_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so the negedge view is stable
    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (timeout_err) to_pulses <= to_pulses + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        con_valid = 1'b0; con_data = 8'h00; con_last = 1'b0;
        rsp_valid = 1'b0; rsp_data = 8'h00; rsp_last = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tx_log.delete(); exp_q.delete(); con_q.delete(); rsp_q.delete();
    endtask

    task automatic q_rsp(input logic [31:0] pl);
        rsp_q.push_back({1'b0, SU_CMD_RSP});
        rsp_q.push_back({1'b0, pl[31:24]});
        rsp_q.push_back({1'b0, pl[23:16]});
        rsp_q.push_back({1'b0, pl[15:8]});
        rsp_q.push_back({1'b1, pl[7:0]});
    endtask

    task automatic e_rsp(input logic [31:0] pl);
        exp_q.push_back(SU_CMD_RSP);
        exp_q.push_back(pl[31:24]);
        exp_q.push_back(pl[23:16]);
        exp_q.push_back(pl[15:8]);
        exp_q.push_back(pl[7:0]);
    endtask

    task automatic chk_stream(input string tag);
        logic [31:0] obs;
        chk({tag, "_len"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s[%0d]", tag, i), obs, {24'h0, exp_q[i]});
        end
    endtask

    // Drives both sources from their queues until everything has drained
    task automatic run(input string tag, input int max_cyc, input int stall_at, input int stall_len);
        bit con_acc, rsp_acc, done;
        done = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            con_valid = (con_q.size() != 0);
            con_data  = con_valid ? con_q[0][7:0] : 8'h00;
            con_last  = con_valid ? con_q[0][8] : 1'b0;
            rsp_valid = (rsp_q.size() != 0);
            rsp_data  = rsp_valid ? rsp_q[0][7:0] : 8'h00;
            rsp_last  = rsp_valid ? rsp_q[0][8] : 1'b0;
            tx_ready  = !((c >= stall_at) && (c < stall_at + stall_len));
            @(negedge clk);
            if (!tx_ready) begin
                if (c == stall_at) held = tx_data;
                else chk("bp_hold", tx_data, held);
                chk("bp_rsp_ready", rsp_ready, 0);
                chk("bp_tx_valid", tx_valid, 1);
            end
            con_acc = con_valid && con_ready;
            rsp_acc = rsp_valid && rsp_ready;
            tick();
            if (con_acc) void'(con_q.pop_front());
            if (rsp_acc) void'(rsp_q.pop_front());
            if (con_q.size() == 0 && rsp_q.size() == 0 && !tx_valid && grant == 2'b00) begin
                done = 1'b1;
                break;
            end
        end
        con_valid = 1'b0; rsp_valid = 1'b0; tx_ready = 1'b1;
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_grant", grant, 2'b00);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_ready", {con_ready, rsp_ready}, 2'b00);

        // ---------------- console only: "AB\n" ----------------
        do_reset();
        con_valid = 1'b1; con_data = 8'h41; con_last = 1'b0;
        @(negedge clk);
        chk("con_idle_ready", con_ready, 0);
        tick();
        @(negedge clk);
        chk("con_grant", grant, SU_GNT_CON);
        chk("con_ready", con_ready, 1);
        chk("con_rsp_ready", rsp_ready, 0);
        tick();
        con_data = 8'h42;
        @(negedge clk);
        chk("con_b0_valid", tx_valid, 1);
        chk("con_b0", tx_data, 8'h41);
        tick();
        con_data = 8'h0A; con_last = 1'b1;
        @(negedge clk);
        chk("con_b1", tx_data, 8'h42);
        tick();
        con_valid = 1'b0; con_last = 1'b0;
        @(negedge clk);
        chk("con_b2", tx_data, 8'h0A);
        chk("con_grant_end", grant, 2'b00);
        tick();
        @(negedge clk);
        chk("con_drained", tx_valid, 0);

        // ---------------- collision ----------------
        do_reset();
        con_q.push_back({1'b0, 8'h4F});
        con_q.push_back({1'b1, 8'h0A});
        q_rsp(32'hDEAD_BEEF);
        e_rsp(32'hDEAD_BEEF);
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h0A);
        run("coll", 100, 1000, 0);
        chk_stream("coll");

        // ---------------- starvation guard ----------------
        do_reset();
        con_q.push_back({1'b1, 8'h43});
        for (int k = 1; k <= 6; k++) q_rsp({8'h10 * k[7:0], 8'h01, 8'h02, 8'h03});
        for (int k = 1; k <= 4; k++) e_rsp({8'h10 * k[7:0], 8'h01, 8'h02, 8'h03});
        exp_q.push_back(8'h43);
        for (int k = 5; k <= 6; k++) e_rsp({8'h10 * k[7:0], 8'h01, 8'h02, 8'h03});
        run("starve", 200, 1000, 0);
        chk_stream("starve");

        // ---------------- backpressure ----------------
        do_reset();
        pulses_base = to_pulses;
        q_rsp(32'h0102_0304);
        e_rsp(32'h0102_0304);
        run("bp", 100, 3, 10);
        chk("bp_held_byte", held, 8'h01);
        chk_stream("bp");
        chk("bp_no_timeout", to_pulses - pulses_base, 0);

        // ---------------- timeout ----------------
        do_reset();
        pulses_base = to_pulses;
        con_valid = 1'b1; con_data = 8'h55; con_last = 1'b0;
        tick();                     // grant console
        tick();                     // 0x55 accepted
        con_valid = 1'b0;
        rsp_valid = 1'b1; rsp_data = SU_CMD_RSP; rsp_last = 1'b0;
        repeat (19) tick();         // 19 idle cycles elapse
        @(negedge clk);
        chk("to_before_pulse", timeout_err, 0);
        chk("to_before_grant", grant, SU_GNT_CON);
        chk("to_other_ready", rsp_ready, 0);
        tick();                     // end of 20th idle cycle
        @(negedge clk);
        chk("to_pulse", timeout_err, 1);
        chk("to_grant_idle", grant, 2'b00);
        tx_log.delete();
        q_rsp(32'h1234_5678);
        e_rsp(32'h1234_5678);
        run("to_regrant", 100, 1000, 0);
        chk_stream("to_regrant");
        chk("to_one_pulse", to_pulses - pulses_base, 1);

        // ---------------- reset mid-packet ----------------
        do_reset();
        rsp_valid = 1'b1; rsp_data = SU_CMD_RSP; rsp_last = 1'b0;
        tick();                     // grant response
        tick();                     // byte 1 accepted
        rsp_data = 8'h11;
        tick();                     // byte 2 accepted
        rsp_data = 8'h22;
        rstn = 1'b0;                // during byte 3
        @(negedge clk);
        chk("mr_pre_data", tx_data, 8'h11);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("mr_tx_valid", tx_valid, 0);
        chk("mr_grant", grant, 2'b00);
        chk("mr_rsp_ready", rsp_ready, 0);
        tick();
        @(negedge clk);
        chk("mr_regrant", grant, SU_GNT_RSP);
        chk("mr_regrant_ready", rsp_ready, 1);
        rsp_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/su_tx_arbiter.md
Name: su_tx_arbiter

Overview:
- Shares the single UART TX byte stream between two sources:
  - console source: core/APB terminal output, one packet per text line;
  - smart-uart response source: SU_CMD_RSP byte plus 4 data bytes.
- Grants whole packets, so a 5-byte SU response never interleaves with console text. Without this, the host side mis-parses the response byte count.
- Sits between the two sources and the uart_tx serializer.
- Adds one registered output stage and a stall timeout that releases a hung requester.

Parameters:
- MAX_RSP_BURST, 4: maximum consecutive response packets granted while the console is waiting.
- TIMEOUT_CYCLES, 100000: idle cycles inside a granted packet before forced release. 0 disables the timeout.
- TO_CNT_W, 17: width of the timeout counter. Must satisfy 2^TO_CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous active-low reset
- con_valid  input  1  console byte valid
- con_data  input  8  console byte
- con_last  input  1  last byte of console packet
- con_ready  output  1  console byte accepted
- rsp_valid  input  1  response byte valid
- rsp_data  input  8  response byte
- rsp_last  input  1  last byte of response packet
- rsp_ready  output  1  response byte accepted
- tx_valid  output  1  byte valid to uart_tx
- tx_data  output  8  byte to uart_tx
- tx_ready  input  1  uart_tx accepts byte
- grant  output  2  one-hot current owner: [0] console, [1] response; 00 when idle
- timeout_err  output  1  one-cycle pulse on forced release

Behaviour:
- Clock and reset: one clock domain, clk. Reset on rstn is synchronous, active-low.
- Reset values: state IDLE, tx_valid 0, tx_data 0x00, grant 00, timeout_err 0, all counters 0.
- Reset mid-packet: output register is cleared and the byte is dropped; the partial packet is lost. No recovery framing is generated.
- Handshakes: valid/ready on all three interfaces.
  - A beat transfers when valid && ready are both high on a rising edge.
  - Sources must hold data and last stable while valid is high and ready is low.
- FSM states: IDLE, GNT_CON, GNT_RSP.
- IDLE arbitration:
  - Only rsp_valid high -> GNT_RSP.
  - Only con_valid high -> GNT_CON.
  - Both high -> GNT_RSP, unless rsp_burst_cnt == MAX_RSP_BURST, then GNT_CON.
  - Arbitration costs one cycle. No ready is asserted in IDLE.
- rsp_burst_cnt:
  - Increments on each response packet completion, saturating at MAX_RSP_BURST.
  - Clears when a console packet completes.
  - Also clears on any grant decision taken while con_valid is low.
- Ready generation:
  - con_ready = (state==GNT_CON) && (!tx_valid || tx_ready).
  - rsp_ready uses the same rule with GNT_RSP. Combinational.
  - The non-granted ready is always 0.
- Output register:
  - An accepted beat loads tx_data and sets tx_valid on the next edge.
  - tx_valid clears when tx_ready is high and no new beat is accepted in the same cycle.
  - Back-to-back throughput is 1 byte/cycle when tx_ready stays high.
  - Latency from source accept to tx_valid is 1 cycle.
- Packet end: accepting a beat with last=1 returns the FSM to IDLE on the next edge.
  - The buffered byte still drains from the output register.
  - The next grant may be decided while that byte drains.
- grant: reflects the FSM state (registered).
- Timeout, active only in GNT_*:
  - to_cnt increments each cycle the granted source has valid low; it does not count while tx_ready is low.
  - to_cnt clears on each accepted beat and on entry to a grant.
  - When to_cnt reaches TIMEOUT_CYCLES: FSM -> IDLE, timeout_err pulses for 1 cycle, to_cnt clears.
  - A byte already in the output register still drains.
- Simultaneous events:
  - last-beat accept and timeout in the same cycle: the accept wins; no timeout_err pulse.
  - A source deasserting valid mid-packet is legal; it counts toward the timeout only.

Decomposition:
- Add to smart_uart_pkg:
  - typedef enum su_arb_state_t {IDLE, GNT_CON, GNT_RSP};
  - constants SU_GNT_CON=2'b01 and SU_GNT_RSP=2'b10.
  - SU_RSP_LEN=5, for bench checking.
- One natural sub-module: su_tx_out_reg, the single-entry registered valid/ready stage.
- FSM and counters stay in the top.

Test Plan:
- Console-only: console sends "AB\n" (0x41, 0x42, 0x0A; last on 0x0A), tx_ready=1.
  - Required: grant=01 one cycle after con_valid.
  - tx_data sequence 41, 42, 0A on consecutive cycles; then grant returns to 00.
- Collision: con_valid and rsp_valid rise on the same cycle; response packet is SU_CMD_RSP then DE AD BE EF.
  - Required: all 5 response bytes appear contiguously on tx, then the console packet follows.
  - No interleaving at any point.
- Starvation guard, MAX_RSP_BURST=4: response source streams 6 packets while the console holds a 1-byte packet.
  - Required: the console packet is sent after response packet 4 and before packet 5.
- Backpressure: tx_ready low for 10 cycles mid-response.
  - Required: tx_data holds its byte and rsp_ready stays 0.
  - No byte is lost or duplicated; no timeout fires.
- Timeout, TIMEOUT_CYCLES=20: console sends 1 byte without last, then drops valid.
  - Required: timeout_err pulses on the 20th idle cycle and grant goes to 00.
  - A pending response packet is granted on the next arbitration.
- Reset mid-packet: rstn low for 1 cycle during response byte 3.
  - Required: tx_valid=0, grant=00, state IDLE on the next edge.
  - The rsp_valid still high re-arbitrates after rstn returns high.
